// File: rtl/sm_fetch_queue.sv
// ============================================================================
// sm_fetch_queue
//   Instruction prefetch queue. Issues sequential word-address reads to an
//   instruction memory (one outstanding request, req/ack handshake), buffers
//   returned words in a DEPTH-entry FIFO and presents the head entry to the
//   CPU. A redirect flushes the queue and restarts fetching at a new address.
//   If a redirect lands while a read is still in flight, that read is allowed
//   to finish with mem_addr held, and its data is thrown away.
//
// Parameters
//   DEPTH       queue entries (power of two, 2..16)
//   RESET_ADDR  first word address fetched after reset
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   redirect        flush queue and refetch from redirect_addr
//   redirect_addr   new word address
//   deq             CPU consumes head instruction (ignored when not valid)
//   instr           head instruction word (0 when not valid)
//   instr_addr      word address of head instruction (0 when not valid)
//   instr_valid     instr / instr_addr meaningful
//   mem_req         memory read request
//   mem_addr        word address of the read
//   mem_ack         read complete, mem_rdata valid
//   mem_rdata       read data
//
// Build option
//   SM_FETCH_BYPASS_EN  when defined, a word returning into an empty queue is
//                       shown on instr in the same cycle as its ack.
// ============================================================================
module sm_fetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        deq,
    output logic [31:0] instr,
    output logic [31:0] instr_addr,
    output logic        instr_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_pc;            // address of the current / next request
    logic [31:0]   w_pc_next;
    logic [31:0]   r_target;        // restart address while in S_DROP
    logic [31:0]   w_target_next;

    logic [31:0]   r_data   [DEPTH];
    logic [31:0]   r_iaddr  [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    logic          w_live;          // live transfer completing this cycle
    logic          w_qvalid;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;

    assign w_qvalid = (r_count != '0);
    assign w_live   = (r_state == S_REQ) && mem_ack && !redirect;

`ifdef SM_FETCH_BYPASS_EN
    assign w_bypass = w_live && !w_qvalid && !rst;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that the CPU takes in the same cycle never enters the queue.
    assign w_push = w_live && !(w_bypass && deq);
    assign w_pop  = deq && w_qvalid && !redirect;

    always_comb begin
        w_count_next = r_count;
        if (redirect)
            w_count_next = '0;
        else
            w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_ADDR;
            r_target <= RESET_ADDR;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_target <= w_target_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_target_next = r_target;
        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_pc_next    = redirect_addr;
                    w_state_next = S_REQ;
                end else if (r_count < FULL) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    if (mem_ack) begin
                        w_pc_next = redirect_addr;
                    end else begin
                        w_target_next = redirect_addr;
                        w_state_next  = S_DROP;
                    end
                end else if (mem_ack) begin
                    w_pc_next = r_pc + 32'd1;
                    if (w_count_next == FULL)
                        w_state_next = S_IDLE;
                end
            end
            S_DROP: begin
                if (mem_ack) begin
                    w_pc_next    = redirect ? redirect_addr : r_target;
                    w_state_next = S_REQ;
                end else if (redirect) begin
                    w_target_next = redirect_addr;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_req     = (r_state != S_IDLE);
        mem_addr    = r_pc;
        instr_valid = w_qvalid || w_bypass;
        instr       = '0;
        instr_addr  = '0;
        if (w_qvalid) begin
            instr      = r_data[r_head];
            instr_addr = r_iaddr[r_head];
        end else if (w_bypass) begin
            instr      = mem_rdata;
            instr_addr = r_pc;
        end
    end

    // ---------------- queue storage ----------------
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_data[r_tail]  <= mem_rdata;
            r_iaddr[r_tail] <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + AW'(1);
            if (w_pop)
                r_head <= r_head + AW'(1);
            r_count <= w_count_next;
        end
    end

endmodule
